// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key expander and the round datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int AES_KEY_W = 128;

  typedef logic [31:0]          word_t;
  typedef logic [AES_KEY_W-1:0] key_t;
  typedef logic [3:0]           round_t;

  typedef enum logic {
    IDLE,
    EMIT
  } kx_state_t;

  // Round constants; entry r is used while producing round key r+1.
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Rcon for the key following round r; rounds past the table yield 0 so the
  // lookup stays in range while round 10 is parked on the output.
  function automatic logic [7:0] rcon_lookup(input round_t r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r < round_t'(NR_AES128)) begin
      rc = RCON[r];
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Handshake bundle between the key expander and its consumer / control.
// Latency: n/a (wires only).
// Backpressure: rk_valid/rk_ready on the round-key stream; start is level-sampled while idle.
//   start/key_in      : launch an expansion of key_in
//   busy/done         : expansion status, done is a one-cycle pulse
//   rk_valid/rk_ready : round-key stream, rk_out/rk_round carry the key and its index
//   rk_rd_addr/data   : random read port into the optional round-key store
interface aes_key_expander_if;
  import aes_pkg::*;

  logic   start;
  key_t   key_in;
  logic   busy;
  logic   rk_valid;
  logic   rk_ready;
  key_t   rk_out;
  round_t rk_round;
  logic   done;
  round_t rk_rd_addr;
  key_t   rk_rd_data;

  // master: the controller / consumer side
  modport master (
    output start, key_in, rk_ready, rk_rd_addr,
    input  busy, rk_valid, rk_out, rk_round, done, rk_rd_data
  );

  // slave: the key expander itself
  modport slave (
    input  start, key_in, rk_ready, rk_rd_addr,
    output busy, rk_valid, rk_out, rk_round, done, rk_rd_data
  );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, 8-bit to 8-bit lookup.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//   plain : input byte
//   subst : substituted byte
module aes_sbox (
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[plain];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 round-key generator: expands key_in into round keys 0..10, one per transfer.
// Latency: round 0 valid 1 cycle after an accepted start; 1 key/cycle with rk_ready held high.
// Backpressure: rk_out/rk_round hold while rk_valid & !rk_ready; start ignored while busy.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aes_key_expander_if.slave (start/key_in, busy/done, rk_* stream, rk_rd_* port)
// Build option: define ROUND_KEY_STORE_EN to keep an 11-entry copy of the emitted keys
// readable through rk_rd_addr/rk_rd_data; otherwise rk_rd_data reads as 0.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input logic          clk,
  input logic          rst,
  aes_key_expander_if.slave bus
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_key_expander: only NR=10 (AES-128) is supported");
  end
  if (KEY_W != AES_KEY_W) begin : g_bad_key_w
    $error("aes_key_expander: KEY_W must be 128");
  end

  kx_state_t state_q, state_d;
  key_t      key_q, key_d;
  round_t    round_q, round_d;
  logic      done_q, done_d;
  logic      xfer;
  logic      last_round;

  word_t w0, w1, w2, w3;
  word_t rot_w, sub_w, t_w;
  word_t nw0, nw1, nw2, nw3;
  key_t  next_key;

  assign xfer       = bus.rk_valid & bus.rk_ready;
  assign last_round = (round_q == round_t'(NR_AES128));

  // Next round key, derived combinationally from the key currently presented.
  assign {w0, w1, w2, w3} = key_q;
  assign rot_w = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .plain (rot_w[8*i +: 8]),
      .subst (sub_w[8*i +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon_lookup(round_q), 24'h0};
  assign nw0      = w0 ^ t_w;
  assign nw1      = w1 ^ nw0;
  assign nw2      = w2 ^ nw1;
  assign nw3      = w3 ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Only reachable when not busy, so this is the single place start is honoured.
        if (bus.start) begin
          key_d   = bus.key_in;
          round_d = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_round) begin
            // Round 10 stays on rk_out; only the state and done change.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + round_t'(1);
          end
        end
      end
    endcase
  end

  assign bus.busy     = (state_q == EMIT);
  assign bus.rk_valid = (state_q == EMIT);
  assign bus.rk_out   = key_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

`ifdef ROUND_KEY_STORE_EN
  key_t store_q [0:NR_AES128];

  // Cleared only by reset, so keys from the previous expansion stay readable
  // until they are overwritten by the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR_AES128; i++) begin
        store_q[i] <= '0;
      end
    end else if (xfer) begin
      store_q[round_q] <= key_q;
    end
  end

  assign bus.rk_rd_data = (bus.rk_rd_addr <= round_t'(NR_AES128)) ? store_q[bus.rk_rd_addr] : '0;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rk_rd_addr;
  assign bus.rk_rd_data = '0;
`endif

endmodule
